// File: rtl/pcpi_issue_ctrl.sv
// pcpi_issue_ctrl: PCPI initiator that issues one queued custom instruction at a time
// Ports:
//   clk, resetn                   clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake; cmd_insn/cmd_rs1/cmd_rs2 payload
//   rsp_valid/rsp_ready           response handshake; rsp_data/rsp_wr/rsp_trap payload
//   pcpi_valid/insn/rs1/rs2       request driven to the coprocessors
//   pcpi_wr/rd/wait/ready         coprocessor replies
//   stat_done/stat_trap           saturating completed/trapped transaction counters
module pcpi_issue_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_insn,
  input  logic [31:0]      cmd_rs1,
  input  logic [31:0]      cmd_rs2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_wr,
  output logic             rsp_trap,
  output logic             pcpi_valid,
  output logic [31:0]      pcpi_insn,
  output logic [31:0]      pcpi_rs1,
  output logic [31:0]      pcpi_rs2,
  input  logic             pcpi_wr,
  input  logic [31:0]      pcpi_rd,
  input  logic             pcpi_wait,
  input  logic             pcpi_ready,
  output logic [CNT_W-1:0] stat_done,
  output logic [CNT_W-1:0] stat_trap
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t           r_state, w_next;
  logic [TW-1:0]    r_timer;
  logic [31:0]      r_insn, r_rs1, r_rs2, r_rsp_data;
  logic             r_rsp_wr, r_rsp_trap;
  logic [CNT_W-1:0] r_done, r_trap;
  logic             w_accept, w_done, w_trap;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  // ready takes priority over the timeout when both land in the same cycle
  always_comb begin
    w_accept   = r_state == IDLE && cmd_valid;
    w_done     = r_state == BUSY && pcpi_ready;
    w_trap     = r_state == BUSY && !pcpi_ready && !pcpi_wait && r_timer == TW'(1);
    w_next     = r_state == IDLE ? (cmd_valid ? BUSY : IDLE) :
                 r_state == BUSY ? ((w_done || w_trap) ? RESP : BUSY) :
                                   (rsp_ready ? IDLE : RESP);
    cmd_ready  = r_state == IDLE;
    pcpi_valid = r_state == BUSY;
    rsp_valid  = r_state == RESP;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_timer    <= '0;
      r_insn     <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rsp_data <= '0;
      r_rsp_wr   <= 1'b0;
      r_rsp_trap <= 1'b0;
      r_done     <= '0;
      r_trap     <= '0;
    end else begin
      if (w_accept) begin
        r_insn  <= cmd_insn;
        r_rs1   <= cmd_rs1;
        r_rs2   <= cmd_rs2;
        r_timer <= TW'(TIMEOUT);
      end else if (r_state == BUSY)
        r_timer <= pcpi_wait ? TW'(TIMEOUT) : r_timer - TW'(1);
      if (w_done) begin
        r_rsp_wr   <= pcpi_wr;
        r_rsp_data <= pcpi_wr ? pcpi_rd : '0;
        r_rsp_trap <= 1'b0;
        r_done     <= r_done + CNT_W'(r_done != '1);
      end
      if (w_trap) begin
        r_rsp_wr   <= 1'b0;
        r_rsp_data <= '0;
        r_rsp_trap <= 1'b1;
        r_trap     <= r_trap + CNT_W'(r_trap != '1);
      end
    end
  assign pcpi_insn = r_insn;
  assign pcpi_rs1  = r_rs1;
  assign pcpi_rs2  = r_rs2;
  assign rsp_data  = r_rsp_data;
  assign rsp_wr    = r_rsp_wr;
  assign rsp_trap  = r_rsp_trap;
  assign stat_done = r_done;
  assign stat_trap = r_trap;
endmodule

// File: tb/tb_pcpi_issue_ctrl.sv
// tb_pcpi_issue_ctrl: table-driven scoreboard bench for pcpi_issue_ctrl
module tb_pcpi_issue_ctrl;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic resetn, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_wr, rsp_trap;
  logic pcpi_valid, pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] cmd_insn, cmd_rs1, cmd_rs2, rsp_data, pcpi_insn, pcpi_rs1, pcpi_rs2, pcpi_rd;
  logic [CNT_W-1:0] stat_done, stat_trap;
  pcpi_issue_ctrl #(.TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_insn(cmd_insn), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_wr(rsp_wr), .rsp_trap(rsp_trap),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .stat_done(stat_done), .stat_trap(stat_trap)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] insn, rs1, rs2;
    int          idle, wt, post;
    bit          rdy, wr;
    logic [31:0] rd;
    int          hold, ebusy;
    bit          etrap, ewr;
    logic [31:0] edata;
  } vec_t;
  typedef struct {
    logic [31:0] data;
    bit          wr, trap;
  } rsp_t;
  vec_t v[11];
  rsp_t sb[$];
  int checks = 0, errors = 0, n_done = 0, n_trap = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [CNT_W-1:0] sat(input int n);
    return CNT_W'(n > CNT_MAX ? CNT_MAX : n);
  endfunction
  task automatic clear_pcpi();
    pcpi_wait = 0; pcpi_ready = 0; pcpi_wr = 0; pcpi_rd = 0;
  endtask
  task automatic run_vec(input vec_t t);
    int busy;
    rsp_t e;
    chk("gap_valid_low", pcpi_valid, 0);
    chk("idle_cmd_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_insn = t.insn; cmd_rs1 = t.rs1; cmd_rs2 = t.rs2;
    sb.push_back('{t.edata, t.ewr, t.etrap});
    if (t.etrap) n_trap++; else n_done++;
    @(negedge clk);
    cmd_valid = 0; cmd_insn = 32'hFFFF_FFFF;
    chk("accept_latency", pcpi_valid, 1);
    chk("pcpi_insn", pcpi_insn, t.insn);
    chk("pcpi_rs1", pcpi_rs1, t.rs1);
    chk("pcpi_rs2", pcpi_rs2, t.rs2);
    busy = 0;
    for (int c = 1; c <= 200; c++) begin
      clear_pcpi();
      if (c > t.idle && c <= t.idle + t.wt) pcpi_wait = 1;
      else if (c > t.idle + t.wt + t.post && t.rdy) begin
        pcpi_ready = 1; pcpi_wr = t.wr; pcpi_rd = t.rd;
      end else begin
        pcpi_wr = 1; pcpi_rd = 32'hBAD0_0000 | c;
      end
      @(negedge clk);
      if (!pcpi_valid) begin busy = c; break; end
    end
    clear_pcpi();
    chk("busy_cycles", busy, t.ebusy);
    chk("resp_valid", rsp_valid, 1);
    chk("resp_cmd_ready", cmd_ready, 0);
    chk("stat_done", stat_done, sat(n_done));
    chk("stat_trap", stat_trap, sat(n_trap));
    for (int h = 0; h < t.hold; h++) begin
      rsp_ready = 0; cmd_valid = 1;
      pcpi_ready = 1; pcpi_wr = 1; pcpi_rd = 32'hDEAD_BEEF;
      #1;
      e = sb[0];
      chk("hold_valid", rsp_valid, 1);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_data", rsp_data, e.data);
      chk("hold_wr", rsp_wr, e.wr);
      chk("hold_trap", rsp_trap, e.trap);
      @(negedge clk);
    end
    cmd_valid = 0; clear_pcpi(); rsp_ready = 1;
    #1;
    e = sb.pop_front();
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_data", rsp_data, e.data);
    chk("rsp_wr", rsp_wr, e.wr);
    chk("rsp_trap", rsp_trap, e.trap);
    @(negedge clk);
    rsp_ready = 0;
    chk("back_idle", cmd_ready, 1);
    chk("stat_done_after", stat_done, sat(n_done));
    chk("stat_trap_after", stat_trap, sat(n_trap));
  endtask
  initial begin
    v[0]  = '{32'h0000_4023, 32'h8, 32'h1B, 1, 0, 0, 1, 0, 32'hAAAA_5555, 0, 2, 0, 0, 32'h0};
    v[1]  = '{32'h0800_0033, 32'h3, 32'h5, 0, 4, 0, 1, 1, 32'hF, 0, 5, 0, 1, 32'hF};
    v[2]  = '{32'h0000_0013, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 16, 1, 0, 32'h0};
    v[3]  = '{32'h0A00_0033, 32'h11, 32'h22, 0, 40, 0, 1, 1, 32'h1234, 0, 41, 0, 1, 32'h1234};
    v[4]  = '{32'h0200_00B3, 32'h7, 32'h9, 0, 0, 0, 1, 1, 32'h3F, 5, 1, 0, 1, 32'h3F};
    v[5]  = '{32'h0C00_0033, 32'h1, 32'h2, 15, 0, 0, 1, 1, 32'hCAFE, 0, 16, 0, 1, 32'hCAFE};
    v[6]  = '{32'h0E00_0033, 32'h4, 32'h4, 16, 0, 0, 1, 1, 32'hCAFE, 0, 16, 1, 0, 32'h0};
    v[7]  = '{32'h1000_0033, 32'h5, 32'h6, 12, 1, 15, 1, 1, 32'hBEEF, 2, 29, 0, 1, 32'hBEEF};
    v[8]  = '{32'h1200_0033, 32'h6, 32'h7, 12, 1, 16, 1, 1, 32'hBEEF, 0, 29, 1, 0, 32'h0};
    v[9]  = '{32'h1400_0033, 32'h8, 32'h9, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 1, 1, 0, 0, 32'h0};
    v[10] = '{32'h1600_0033, 32'h1, 32'h1, 2, 3, 0, 1, 1, 32'h55, 0, 6, 0, 1, 32'h55};
    resetn = 0; cmd_valid = 0; cmd_insn = 0; cmd_rs1 = 0; cmd_rs2 = 0; rsp_ready = 0;
    clear_pcpi();
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_pcpi_valid", pcpi_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_stat_done", stat_done, 0);
    chk("rst_stat_trap", stat_trap, 0);
    resetn = 1;
    @(negedge clk);
    pcpi_ready = 1; pcpi_wait = 1; pcpi_wr = 1; pcpi_rd = 32'h77;
    repeat (3) @(negedge clk);
    chk("idle_ready_ignored", rsp_valid, 0);
    chk("idle_no_issue", pcpi_valid, 0);
    chk("idle_stat_done", stat_done, 0);
    clear_pcpi();
    for (int i = 0; i < 11; i++) run_vec(v[i]);
    cmd_valid = 1; cmd_insn = 32'h0800_0033; cmd_rs1 = 1; cmd_rs2 = 2;
    @(negedge clk);
    cmd_valid = 0;
    repeat (2) @(negedge clk);
    chk("pre_reset_busy", pcpi_valid, 1);
    #2 resetn = 0;
    #1;
    chk("async_pcpi_valid", pcpi_valid, 0);
    chk("async_cmd_ready", cmd_ready, 1);
    chk("async_rsp_valid", rsp_valid, 0);
    chk("async_stat_done", stat_done, 0);
    chk("async_stat_trap", stat_trap, 0);
    sb.delete();
    n_done = 0; n_trap = 0;
    @(negedge clk);
    resetn = 1;
    @(negedge clk);
    run_vec(v[0]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
